// File: rtl/rs_cmd_gen.sv
// rs_cmd_gen: debounced push-buttons to clean, gapped RS trigger commands.
// In: clk, rst (async high), btn_s, btn_r (raw). Out: S, R, busy, q_model, conflict.
module rs_cmd_gen #(
  parameter int DB_CYCLES = 16,
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s,
  input  logic btn_r,
  output logic S,
  output logic R,
  output logic busy,
  output logic q_model,
  output logic conflict
);

  localparam int DBW =
    (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PW =
    (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int GW =
    (GAP_W > 1) ? $clog2(GAP_W) : 1;

  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST =
    PW'(PULSE_W - 1);
  localparam logic [GW-1:0] G_LAST =
    GW'(GAP_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SET_P,
    RST_P,
    GAP
  } state_t;

  // Channel 0 is set, channel 1 is reset.
  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     stb;
  logic [1:0]     stb_d;
  logic [1:0]     evt;
  logic [DBW-1:0] cnt [2];

  state_t         state;
  logic [PW-1:0]  pcnt;
  logic [GW-1:0]  gcnt;
  logic           pend_v;
  logic           pend_k;

  logic           set_e;
  logic           one_e;
  logic           both_e;
  logic           gap_end;
  logic           launch;
  logic           launch_k;

  assign raw = {btn_r, btn_s};

  // Synchroniser, debounce and press detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stb    <= '0;
      stb_d  <= '0;
      evt    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      stb_d <= stb;
      evt   <= stb & ~stb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign set_e  = evt[0];
  assign one_e  = evt[0] ^ evt[1];
  assign both_e = evt[0] & evt[1];

  assign gap_end =
    (state == GAP) && (gcnt == G_LAST);

  // A gap ending with nothing pending lets a
  // fresh event start directly, so it is not lost.
  always_comb begin
    launch   = 1'b0;
    launch_k = 1'b0;
    if (state == IDLE) begin
      launch   = one_e;
      launch_k = set_e;
    end else if (gap_end) begin
      launch   = pend_v | one_e;
      launch_k = pend_v ? pend_k : set_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      gcnt     <= '0;
      pend_v   <= 1'b0;
      pend_k   <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      q_model  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      conflict <= both_e;

      if (state != IDLE) begin
        if (gap_end && !pend_v) begin
          pend_v <= 1'b0;
        end else if (one_e) begin
          pend_v <= 1'b1;
          pend_k <= set_e;
        end else if (gap_end) begin
          pend_v <= 1'b0;
        end
      end

      if (launch) begin
        state   <= launch_k ? SET_P : RST_P;
        S       <= launch_k;
        R       <= ~launch_k;
        q_model <= launch_k;
        pcnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            S <= 1'b0;
            R <= 1'b0;
          end
          SET_P, RST_P: begin
            if (pcnt == P_LAST) begin
              state <= GAP;
              S     <= 1'b0;
              R     <= 1'b0;
              gcnt  <= '0;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
          GAP: begin
            if (gap_end) begin
              state <= IDLE;
            end else begin
              gcnt <= gcnt + GW'(1);
            end
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rs_cmd_gen.sv
// tb_rs_cmd_gen: directed bench for rs_cmd_gen.
// Issued pulses are matched against a queue of expected commands.
module tb_rs_cmd_gen;

  localparam int DB  = 16;
  localparam int PW  = 2;
  localparam int GW  = 40;
  localparam int LAT = DB + 3;
  localparam int DEC = LAT + PW + GW;
  localparam int RUN = DEC + PW + GW + 5;

  typedef struct {
    int k;
    int e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_s = 1'b0;
  logic btn_r = 1'b0;
  logic S, R, busy, q_model, conflict;

  int   nchk = 0;
  int   npass = 0;
  int   cyc = 0;
  exp_t sb [$];

  rs_cmd_gen #(
    .DB_CYCLES(DB),
    .PULSE_W(PW),
    .GAP_W(GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_s(btn_s),
    .btn_r(btn_r),
    .S(S),
    .R(R),
    .busy(busy),
    .q_model(q_model),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rise(input int kind);
    exp_t x;
    chk("pulse_expected", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("pulse_kind", kind, x.k);
      chk("pulse_edge", cyc - 1, x.e);
    end
  endtask

  // Pulse monitor: kind 1 = S, kind 0 = R.
  logic ps = 1'b0;
  logic pr = 1'b0;
  int   ws = 0;
  int   wr = 0;
  bit   ab_s = 1'b0;
  bit   ab_r = 1'b0;

  always @(negedge clk) begin
    if (cyc > 2) begin
      chk("s_and_r", int'(S & R), 0);
      if (rst) begin
        ab_s = 1'b1;
        ab_r = 1'b1;
      end
      if (S && !ps) begin
        pulse_rise(1);
        ws   = 0;
        ab_s = 1'b0;
      end
      if (R && !pr) begin
        pulse_rise(0);
        wr   = 0;
        ab_r = 1'b0;
      end
      if (S) ws++;
      if (R) wr++;
      if (!S && ps && !ab_s) chk("s_width", ws, PW);
      if (!R && pr && !ab_r) chk("r_width", wr, PW);
      ps = S;
      pr = R;
    end
  end

  initial begin
    int e0;
    int cc;
    int ce;
    int bad;
    int sf;
    int rr;

    // Reset state
    tick(3);
    chk("rst_S", int'(S), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_q", int'(q_model), 0);
    chk("rst_conflict", int'(conflict), 0);
    rst = 1'b0;
    tick(5);

    // Single set press
    btn_s = 1'b1;
    e0 = cyc;
    sb.push_back('{1, e0 + LAT});
    for (int k = 0; k < DEC + 5; k++) begin
      @(negedge clk);
      if (k == LAT - 1) begin
        chk("t1_q_pre", int'(q_model), 0);
        chk("t1_busy_pre", int'(busy), 0);
      end
      if (k == LAT) begin
        chk("t1_q_post", int'(q_model), 1);
        chk("t1_busy_on", int'(busy), 1);
        chk("t1_R_low", int'(R), 0);
      end
      if (k == DEC - 1) chk("t1_busy_gap", int'(busy), 1);
      if (k == DEC) chk("t1_busy_off", int'(busy), 0);
      if (k == 40) btn_s = 1'b0;
    end
    tick(10);

    // Short glitch on reset button
    btn_r = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 9) btn_r = 1'b0;
      if (busy || S || R) bad++;
    end
    chk("t2_glitch_quiet", bad, 0);

    // Simultaneous presses
    btn_s = 1'b1;
    btn_r = 1'b1;
    cc = 0;
    ce = -1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (conflict) begin
        cc++;
        if (ce < 0) ce = k;
      end
      if (busy) bad++;
    end
    chk("t3_conflict_cnt", cc, 1);
    chk("t3_conflict_edge", ce, LAT);
    chk("t3_no_busy", bad, 0);
    chk("t3_q_kept", int'(q_model), 1);
    btn_s = 1'b0;
    btn_r = 1'b0;
    tick(30);

    // Reset press lands during SET_P
    btn_s = 1'b1;
    e0 = cyc;
    sb.push_back('{1, e0 + LAT});
    sb.push_back('{0, e0 + DEC});
    sf = -1;
    rr = -1;
    for (int k = 0; k < RUN; k++) begin
      @(negedge clk);
      if (k == 0) btn_r = 1'b1;
      if (k == 30) begin
        btn_s = 1'b0;
        btn_r = 1'b0;
      end
      if (k > LAT && !S && sf < 0) sf = k;
      if (R && rr < 0) rr = k;
    end
    chk("t4_gap_len", rr - sf, GW);
    chk("t4_q_final", int'(q_model), 0);
    chk("t4_idle", int'(busy), 0);
    tick(30);

    // Reset then set during one gap
    btn_s = 1'b1;
    e0 = cyc;
    sb.push_back('{1, e0 + LAT});
    sb.push_back('{1, e0 + DEC});
    for (int k = 0; k < RUN; k++) begin
      @(negedge clk);
      if (k == LAT) btn_s = 1'b0;
      if (k == 24) btn_r = 1'b1;
      if (k == 39) btn_s = 1'b1;
      if (k == DEC - 3) chk("t5_gap", int'(busy), 1);
      if (k == 70) begin
        btn_s = 1'b0;
        btn_r = 1'b0;
      end
    end
    chk("t5_q_final", int'(q_model), 1);
    chk("t5_idle", int'(busy), 0);
    tick(30);

    // Reset mid-pulse with a pending reset command
    btn_s = 1'b1;
    e0 = cyc;
    sb.push_back('{1, e0 + LAT});
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 0) btn_r = 1'b1;
      if (k == LAT) chk("t6_S_on", int'(S), 1);
    end
    btn_r = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_S_drop", int'(S), 0);
    chk("t6_busy_drop", int'(busy), 0);
    chk("t6_q_clear", int'(q_model), 0);
    tick(3);
    rst = 1'b0;
    e0 = cyc;
    sb.push_back('{1, e0 + LAT});
    for (int k = 0; k < RUN; k++) begin
      @(negedge clk);
      if (k == LAT - 1) chk("t6_no_early", int'(S), 0);
      if (k == LAT) chk("t6_q_set", int'(q_model), 1);
    end
    chk("t6_idle", int'(busy), 0);
    btn_s = 1'b0;
    tick(30);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/rs_cmd_gen.md
Name: rs_cmd_gen

Overview:
- Driver side of the clocked RS trigger: converts two raw push-buttons (set, reset) into clean, mutually exclusive S/R command pulses with guaranteed hold gaps.
- The downstream trigger never sees S=R=1 (the undefined input combination) and never sees pulses closer together than a fixed gap.
- Sits between the board button pins and the RS trigger / game-control logic.
- Also keeps a model of the expected trigger state for self-checking.

Parameters:
- DB_CYCLES, 16, consecutive clk cycles a synchronised input must disagree with its debounced level before that level flips (board build overrides this to ~1_000_000).
- PULSE_W, 2, clk cycles S or R stays high per command (≥1).
- GAP_W, 4, clk cycles with S=R=0 forced after every pulse (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_s  input  1  raw set button, asynchronous to clk, active-high.
- btn_r  input  1  raw reset button, asynchronous to clk, active-high.
- S  output  1  set command to RS trigger, registered.
- R  output  1  reset command to RS trigger, registered.
- busy  output  1  high whenever FSM is not IDLE.
- q_model  output  1  expected trigger Q after the last issued command.
- conflict  output  1  one-cycle pulse when set and reset press events coincide.

Behaviour:
- Reset (async, immediate): S=R=busy=q_model=conflict=0; sync flops, debounced levels, counters and pending slot cleared; FSM=IDLE.
- Sync: per channel 2-FF synchroniser, no logic between stages.
- Debounce, per channel:
  - cnt increments each edge while sync2 != stable.
  - On the edge where cnt==DB_CYCLES-1 and a mismatch persists: stable<=sync2, cnt<=0.
  - Any edge with sync2==stable clears cnt.
- Press event: registered one-cycle pulse on stable 0→1. Releases generate no event.
- Latency: with edge 0 as the first edge sampling raw high (held stable):
  - stable flips at edge DB_CYCLES+1.
  - event is high after edge DB_CYCLES+2.
  - S or R goes high after edge DB_CYCLES+3 (19 edges at default).
- FSM states: IDLE, SET_P, RST_P, GAP.
  - IDLE: set_evt only → SET_P; rst_evt only → RST_P; both → conflict pulse, stay IDLE.
  - SET_P / RST_P: S (resp. R) high for exactly PULSE_W cycles, then GAP. q_model<=1 (resp. 0) on entry.
  - GAP: S=R=0 for exactly GAP_W cycles.
  - End of GAP: if pending is valid, go to its pulse state and clear pending; else IDLE.
- Pending slot (one deep, valid + kind):
  - Events arriving in SET_P/RST_P/GAP load it; the latest single event overwrites an older one.
  - Both events in the same busy cycle → conflict pulse, pending unchanged.
- An event arriving on the same edge as the GAP→next decision is captured into pending, not lost.
- Invariants:
  - S&R never 1.
  - S/R never high in GAP or IDLE.
  - After the gap, a consecutive pulse starts immediately; there is no extra idle cycle.
- Redundant commands (set while q_model=1) are still issued; the block does not filter them.
- Reset mid-pulse: S/R drop asynchronously and the pending command is discarded. A button still held after reset release is debounced afresh (stable restarts at 0) and produces a new press event.
- Counter widths: $clog2 of the respective parameter, with a minimum of 1 bit.

Test Plan:
- Defaults; btn_s raised at edge 0, held 40 cycles → S high for edges 19–20 only; q_model=1 from edge 19; busy low again after edge 25; R stays 0.
- btn_r glitch high for 10 cycles (< DB_CYCLES) then low → no event, S=R=0, busy=0 throughout.
- btn_s and btn_r rise on the same edge → conflict high exactly one cycle (edge 18→19); S=R=0; q_model unchanged.
- Set press, then reset press arriving during SET_P → R pulse starts exactly GAP_W cycles after S falls; S and R never overlap; final q_model=0.
- Set, reset and set presses all arriving during one GAP → only the last (set) is issued after the gap.
- rst asserted mid-SET_P while btn_s is held → S=0 immediately. After release: fresh S pulse DB_CYCLES+3 edges later; no stale pending command is issued.
